spi_master_tx: RTL

SPI master transmitter that drives SCLK, MOSI and CS_n to send byte frames to an SPI receiver that samples MOSI MSB-first on SCLK rising edges (mode 0, CPOL=0, CPHA=0). It accepts bytes from an upstream producer through a valid/ready handshake. It keeps CS_n asserted across consecutive bytes of one frame and releases CS_n after the byte flagged last. The block serves as the loopback/stimulus source for the LED controller's SPI input path and as the generic SPI output of the design.

---
 rtl/spi_master_tx_if.sv | 34 +++
 rtl/spi_master_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_tx_if
// Description : Byte-stream valid/ready handshake between an upstream producer
//               and the SPI master transmitter.
//                 byte_valid_in  - producer has a byte on byte_data_in
//                 byte_data_in   - byte to send, MSB first
//                 byte_last_in   - byte closes the current frame
//                 byte_ready_out - transmitter accepts a byte this cycle
//               modport slave  : transmitter side
//               modport master : producer side
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_tx_if;
  logic       byte_valid_in;
  logic [7:0] byte_data_in;
  logic       byte_last_in;
  logic       byte_ready_out;

  modport slave (
    input  byte_valid_in,
    input  byte_data_in,
    input  byte_last_in,
    output byte_ready_out
  );

  modport master (
    output byte_valid_in,
    output byte_data_in,
    output byte_last_in,
    input  byte_ready_out
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_tx
// Description : SPI mode-0 master transmitter. Accepts bytes over a
//               valid/ready handshake and shifts them out MSB first, keeping
//               CS_n low across the bytes of one frame and releasing it after
//               the byte flagged last.
//   clk_in       - system clock, rising edge
//   rst_in       - synchronous active-high reset
//   byte_if      - byte handshake (slave modport)
//   busy_out     - high whenever the FSM is not idle
//   done_out     - one-cycle pulse in the first CS_n-high cycle after a frame
//   spi_sclk_out - serial clock, idles low
//   spi_mosi_out - serial data
//   spi_cs_n_out - chip select, active low
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_tx #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  wire              clk_in,
  input  wire              rst_in,
  spi_master_tx_if.slave   byte_if,
  output logic             busy_out,
  output logic             done_out,
  output logic             spi_sclk_out,
  output logic             spi_mosi_out,
  output logic             spi_cs_n_out
);

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] C_DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] C_HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] C_IDLE_LAST  = CW'(CS_IDLE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_last;
  logic          r_sclk;
  logic          r_mosi;
  logic          r_cs_n;
  logic          r_done;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_last_nxt;
  logic          w_phase_nxt;
  logic          w_sclk_nxt;
  logic          w_mosi_nxt;
  logic          w_cs_n_nxt;
  logic          w_done_nxt;
  logic          w_ready;
  logic          w_accept;

  assign w_ready  = ((r_state == S_IDLE) || (r_state == S_WAIT)) && !rst_in;
  assign w_accept = byte_if.byte_valid_in && w_ready;

  assign byte_if.byte_ready_out = w_ready;
  assign busy_out               = (r_state != S_IDLE);
  assign done_out               = r_done;
  assign spi_sclk_out           = r_sclk;
  assign spi_mosi_out           = r_mosi;
  assign spi_cs_n_out           = r_cs_n;

  // State register; SPI outputs are registered from their next values so
  // the pins never glitch.
  always_ff @(posedge clk_in) begin : p_state
    if (rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_last  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_last  <= w_last_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic. Inside SHIFT the registered sclk doubles as the
  // phase flag (0 = low phase, 1 = high phase).
  always_comb begin : p_next
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_last_nxt  = r_last;
    w_phase_nxt = r_sclk;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
          w_shift_nxt = byte_if.byte_data_in;
          w_last_nxt  = byte_if.byte_last_in;
        end
      end
      S_SETUP: begin
        if (r_cnt == C_SETUP_LAST) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_phase_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        if (r_cnt == C_DIV_LAST) begin
          w_cnt_nxt = '0;
          if (!r_sclk) begin
            w_phase_nxt = 1'b1;
          end else begin
            // Falling edge: advance to the next bit, or leave SHIFT with
            // mosi still holding the final bit.
            w_phase_nxt = 1'b0;
            if (r_bit == 3'd7) begin
              w_state_nxt = r_last ? S_HOLD : S_WAIT;
              w_bit_nxt   = '0;
            end else begin
              w_bit_nxt   = r_bit + 3'd1;
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_shift_nxt = byte_if.byte_data_in;
          w_last_nxt  = byte_if.byte_last_in;
        end
      end
      S_HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == C_IDLE_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode of the upcoming state, registered in p_state.
  always_comb begin : p_out
    w_cs_n_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
    w_sclk_nxt = (w_state_nxt == S_SHIFT) && w_phase_nxt;
    w_mosi_nxt = w_cs_n_nxt ? 1'b0 : w_shift_nxt[7];
    w_done_nxt = (r_state == S_HOLD) && (w_state_nxt == S_GAP);
  end

endmodule
`default_nettype wire
